// File: rtl/siso_pkg.sv
// siso_pkg: shared types and constants for the serial frame scheduler
//   sched_state_t : scheduler FSM states
//   REQ_CNT       : number of requesters sharing the lane
//   ID_W          : width of a requester index
package siso_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} sched_state_t;
    localparam int REQ_CNT = 2;
    localparam int ID_W = 1;
endpackage

// File: rtl/siso_lane.sv
// siso_lane: N-bit parallel-load shift register driving one serial bit
//   clk, rst  : clock, synchronous active-high reset
//   load      : capture din
//   shift_en  : advance one bit in the direction given by msb_first
//   msb_first : 1 = emit from bit N-1 downwards, 0 = from bit 0 upwards
//   din       : parallel word
//   sout_bit  : current head bit of the register
module siso_lane #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift_en,
    input  logic         msb_first,
    input  logic [N-1:0] din,
    output logic         sout_bit
);
    logic [N-1:0] sr;
    always_ff @(posedge clk) begin
        if (rst) sr <= '0;
        else if (load) sr <= din;
        else if (shift_en) sr <= msb_first ? {sr[N-2:0], 1'b0} : {1'b0, sr[N-1:1]};
    end
    assign sout_bit = msb_first ? sr[N-1] : sr[0];
endmodule

// File: rtl/siso_frame_sched.sv
// siso_frame_sched: round-robin scheduler sharing one serial lane between two requesters
//   clk, rst          : clock, synchronous active-high reset
//   req_valid         : per-requester word offered
//   req_data0/1       : requester words
//   req_msb_first     : per-requester bit order
//   req_ready         : one-hot combinational accept, only in IDLE
//   sout, sout_valid  : serial data and its qualifier
//   frame_start/last  : first / last bit strobes
//   grant_id          : owner of the current or most recent frame
//   busy              : scheduler not idle
module siso_frame_sched
    import siso_pkg::*;
#(
    parameter int N = 4,
    parameter int GAP = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [REQ_CNT-1:0] req_valid,
    input  logic [N-1:0]       req_data0,
    input  logic [N-1:0]       req_data1,
    input  logic [REQ_CNT-1:0] req_msb_first,
    output logic [REQ_CNT-1:0] req_ready,
    output logic               sout,
    output logic               sout_valid,
    output logic               frame_start,
    output logic               frame_last,
    output logic [ID_W-1:0]    grant_id,
    output logic               busy
);
    localparam int CW = $clog2(N);
    sched_state_t state;
    logic [CW-1:0] cnt;
    logic [3:0] gcnt;
    logic rr_last, order, lane_bit, xfer, sel, shifting, last_bit;
    // Contention goes to the requester that did not win last time.
    assign req_ready = (state != IDLE) ? 2'b00 :
                       (&req_valid) ? (rr_last ? 2'b01 : 2'b10) : req_valid;
    assign xfer = |(req_valid & req_ready);
    assign sel = req_ready[1];
    assign shifting = state == SHIFT;
    assign last_bit = shifting && cnt == CW'(N - 1);
    siso_lane #(.N(N)) u_lane (
        .clk(clk),
        .rst(rst),
        .load(xfer),
        .shift_en(shifting),
        .msb_first(order),
        .din(sel ? req_data1 : req_data0),
        .sout_bit(lane_bit)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            gcnt <= '0;
            rr_last <= 1'b1;
            grant_id <= '0;
            order <= 1'b0;
        end else if (state == IDLE) begin
            if (xfer) begin
                state <= SHIFT;
                cnt <= '0;
                rr_last <= sel;
                grant_id <= sel;
                order <= req_msb_first[sel];
            end
        end else if (shifting) begin
            if (last_bit) begin
                state <= (GAP > 0) ? siso_pkg::GAP : IDLE;
                gcnt <= '0;
            end else cnt <= cnt + 1'b1;
        end else begin
            if (gcnt == 4'(GAP - 1)) state <= IDLE;
            else gcnt <= gcnt + 4'd1;
        end
    end
    assign sout = shifting & lane_bit;
    assign sout_valid = shifting;
    assign frame_start = shifting && cnt == '0;
    assign frame_last = last_bit;
    assign busy = state != IDLE;
endmodule

// File: tb/tb_siso_frame_sched.sv
// tb_siso_frame_sched: directed vector and sequence checks for siso_frame_sched
module tb_siso_frame_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] req_valid = 2'b00, req_msb_first = 2'b00;
    logic [3:0] req_data0 = 4'h0, req_data1 = 4'h0;
    logic [1:0] a_ready, b_ready;
    logic a_sout, a_sv, a_fs, a_fl, a_gid, a_busy;
    logic b_sout, b_sv, b_fs, b_fl, b_gid, b_busy;
    int total = 0, bad = 0;

    siso_frame_sched #(.N(4), .GAP(1)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data0(req_data0),
        .req_data1(req_data1), .req_msb_first(req_msb_first), .req_ready(a_ready),
        .sout(a_sout), .sout_valid(a_sv), .frame_start(a_fs), .frame_last(a_fl),
        .grant_id(a_gid), .busy(a_busy)
    );
    siso_frame_sched #(.N(4), .GAP(0)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data0(req_data0),
        .req_data1(req_data1), .req_msb_first(req_msb_first), .req_ready(b_ready),
        .sout(b_sout), .sout_valid(b_sv), .frame_start(b_fs), .frame_last(b_fl),
        .grant_id(b_gid), .busy(b_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] v;
        logic [3:0] d0;
        logic [3:0] d1;
        logic [1:0] msb;
        logic [1:0] rdy;
        logic       gid;
        logic [3:0] bits;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_stream(input bit use_b, input int ncyc, input logic [3:0] w0, input logic [3:0] w1,
                              input int exp_period, input int exp_lows, input bit alternate);
        int starts[$];
        int ids[$];
        logic [3:0] words[$];
        logic [3:0] w;
        int lows;
        lows = 0;
        w = 4'h0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (use_b ? b_fs : a_fs) begin
                starts.push_back(c);
                ids.push_back(int'(use_b ? b_gid : a_gid));
            end
            if (starts.size() == 1 && !(use_b ? b_sv : a_sv)) lows++;
            if (use_b ? b_sv : a_sv) w = {w[2:0], use_b ? b_sout : a_sout};
            if (use_b ? b_fl : a_fl) words.push_back(w);
            tick();
        end
        chk("stream_frames", starts.size(), 4);
        for (int i = 0; i < starts.size() && i < 4; i++) begin
            chk("stream_gid", ids[i], alternate ? i % 2 : 0);
            if (i > 0) chk("stream_period", starts[i] - starts[i-1], exp_period);
        end
        for (int i = 0; i < words.size() && i < 4; i++)
            chk("stream_word", words[i], (alternate && i % 2 == 1) ? w1 : w0);
        chk("stream_idle_cycles", lows, exp_lows);
    endtask

    initial begin
        int n;
        tbl[0] = '{v: 2'b01, d0: 4'b1011, d1: 4'h0, msb: 2'b01, rdy: 2'b01, gid: 1'b0, bits: 4'b1011};
        tbl[1] = '{v: 2'b10, d0: 4'h0, d1: 4'b1011, msb: 2'b00, rdy: 2'b10, gid: 1'b1, bits: 4'b1101};
        tbl[2] = '{v: 2'b11, d0: 4'b0110, d1: 4'b1111, msb: 2'b11, rdy: 2'b01, gid: 1'b0, bits: 4'b0110};
        tbl[3] = '{v: 2'b01, d0: 4'b1000, d1: 4'h0, msb: 2'b00, rdy: 2'b01, gid: 1'b0, bits: 4'b0001};
        tbl[4] = '{v: 2'b10, d0: 4'h0, d1: 4'b1100, msb: 2'b10, rdy: 2'b10, gid: 1'b1, bits: 4'b1100};

        do_reset();
        @(negedge clk);
        chk("rst_sout", a_sout, 0);
        chk("rst_sout_valid", a_sv, 0);
        chk("rst_start", a_fs, 0);
        chk("rst_last", a_fl, 0);
        chk("rst_gid", a_gid, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_ready", a_ready, 0);

        for (int t = 0; t < 5; t++) begin
            do_reset();
            req_valid = tbl[t].v;
            req_data0 = tbl[t].d0;
            req_data1 = tbl[t].d1;
            req_msb_first = tbl[t].msb;
            @(negedge clk);
            chk("vec_ready", a_ready, tbl[t].rdy);
            tick();
            req_valid = 2'b00;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk("vec_sout", a_sout, tbl[t].bits[3-k]);
                chk("vec_sout_valid", a_sv, 1);
                chk("vec_start", a_fs, k == 0);
                chk("vec_last", a_fl, k == 3);
                chk("vec_gid", a_gid, tbl[t].gid);
                tick();
            end
            @(negedge clk);
            chk("vec_gap_sv", a_sv, 0);
            chk("vec_gap_busy", a_busy, 1);
            tick();
            @(negedge clk);
            chk("vec_idle_busy", a_busy, 0);
        end

        do_reset();
        req_valid = 2'b11;
        req_data0 = 4'hA;
        req_data1 = 4'h5;
        req_msb_first = 2'b11;
        run_stream(1'b0, 24, 4'hA, 4'h5, 6, 2, 1'b1);

        do_reset();
        req_valid = 2'b01;
        req_data0 = 4'b1011;
        req_msb_first = 2'b01;
        run_stream(1'b1, 20, 4'b1011, 4'b1011, 5, 1, 1'b0);

        do_reset();
        req_valid = 2'b01;
        req_data0 = 4'b1111;
        req_msb_first = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        rst = 1'b1;
        req_valid = 2'b11;
        req_data0 = 4'hA;
        req_data1 = 4'h5;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_sout", a_sout, 0);
        chk("abort_sout_valid", a_sv, 0);
        chk("abort_start", a_fs, 0);
        chk("abort_last", a_fl, 0);
        chk("abort_busy", a_busy, 0);
        chk("abort_gid", a_gid, 0);
        chk("abort_ready", a_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("abort_regrant_start", a_fs, 1);
        chk("abort_regrant_gid", a_gid, 0);

        do_reset();
        req_valid = 2'b01;
        req_data0 = 4'b1011;
        req_msb_first = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        req_valid = 2'b10;
        @(negedge clk);
        chk("shift_ready", a_ready, 2'b00);
        tick();
        req_valid = 2'b00;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (a_sv) n++;
            tick();
        end
        chk("no_extra_frame", n, 2);
        req_valid = 2'b01;
        @(negedge clk);
        chk("drop_ready", a_ready, 2'b01);
        #1;
        req_valid = 2'b00;
        tick();
        @(negedge clk);
        chk("drop_busy", a_busy, 0);
        chk("drop_sv", a_sv, 0);
        tick();
        @(negedge clk);
        chk("drop_busy2", a_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
